// File: rtl/rst_pulse_gen.sv
// Reset pulse generator: flop-driven active-low reset pulses with a minimum
// length, a guard interval after each pulse and a one-deep request queue.
module rst_pulse_gen #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MIN_LOW      = 8,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             por,
  input  logic             rst_req,
  input  logic [CNT_W-1:0] rst_len,
  output logic             rst_n_out,
  output logic             busy,
  output logic             req_ack,
  output logic             done,
  output logic             req_ovf
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GUARD  = 2'd2;

  localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_LOW);
  localparam logic [CNT_W-1:0] GUARD_L = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_v, pend_v_nxt;
  logic [CNT_W-1:0] pend_len, pend_len_nxt;
  logic             ack_nxt, done_nxt, ovf_nxt;
  logic [CNT_W-1:0] eff_len;
  logic             direct_start;

  // Requested length is never shorter than the downstream filter needs.
  assign eff_len = (rst_len < MIN_L) ? MIN_L : rst_len;

  // Idle with nothing queued is the only case a request starts a pulse directly.
  assign direct_start = (state == ST_IDLE) && !pend_v;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pend_v_nxt   = pend_v;
    pend_len_nxt = pend_len;
    ack_nxt      = 1'b0;
    done_nxt     = 1'b0;
    ovf_nxt      = req_ovf;

    case (state)
      ST_IDLE: begin
        if (pend_v) begin
          state_nxt  = ST_ASSERT;
          cnt_nxt    = pend_len;
          pend_v_nxt = 1'b0;
        end else if (rst_req) begin
          state_nxt = ST_ASSERT;
          cnt_nxt   = eff_len;
          ack_nxt   = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (cnt == ONE) begin
          state_nxt = ST_GUARD;
          cnt_nxt   = GUARD_L;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      ST_GUARD: begin
        if (cnt == ONE) begin
          if (pend_v) begin
            state_nxt  = ST_ASSERT;
            cnt_nxt    = pend_len;
            pend_v_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Queue or drop requests that cannot start a pulse immediately.
    if (rst_req && !direct_start) begin
      if (pend_v) begin
        ovf_nxt = 1'b1;
      end else begin
        pend_v_nxt   = 1'b1;
        pend_len_nxt = eff_len;
        ack_nxt      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (por) begin
      state     <= ST_ASSERT;
      cnt       <= MIN_L;
      pend_v    <= 1'b0;
      pend_len  <= '0;
      req_ack   <= 1'b0;
      done      <= 1'b0;
      req_ovf   <= 1'b0;
      rst_n_out <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend_v    <= pend_v_nxt;
      pend_len  <= pend_len_nxt;
      req_ack   <= ack_nxt;
      done      <= done_nxt;
      req_ovf   <= ovf_nxt;
      rst_n_out <= (state_nxt != ST_ASSERT);
      busy      <= (state_nxt != ST_IDLE) || pend_v_nxt;
    end
  end

endmodule
